// File: rtl/cache_pkg.sv
// Shared widths and state encoding for the cache controller slice.
package cache_pkg;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 8;
    localparam int INDEX_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CHECK  = 3'd2,
        MEM_RD = 3'd3,
        REFILL = 3'd4,
        WRITE  = 3'd5,
        MEM_WR = 3'd6
    } state_t;
endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache and main-memory signal bundle; slave = controller view, master = surrounding system.
interface cache_controller_if;
    import cache_pkg::*;

    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_w_command;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_read_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cache_rdata, cache_read_hit, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, cache_addr, cache_wdata, cache_w_command,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cache_rdata, cache_read_hit, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, cache_addr, cache_wdata, cache_w_command,
               mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/cache_stat_counter.sv
// 16-bit event counter that sticks at all-ones; async clear on rst.
module cache_stat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (en && count != 16'hFFFF) begin
            count <= count + 16'h0001;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// Sequences CPU reads (lookup, miss fetch + refill) and write-through writes; stalls CPU until done.
// Optional hit/miss statistics enabled by CACHE_CTRL_STATS_EN.
module cache_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    import cache_pkg::state_t;
    import cache_pkg::IDLE;
    import cache_pkg::LOOKUP;
    import cache_pkg::CHECK;
    import cache_pkg::MEM_RD;
    import cache_pkg::REFILL;
    import cache_pkg::WRITE;
    import cache_pkg::MEM_WR;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                // ready_q is still high in the completion cycle while the CPU drops its request
                if (!ready_q) begin
                    if (bus.cpu_wr)      state_n = WRITE;
                    else if (bus.cpu_rd) state_n = LOOKUP;
                end
            end
            LOOKUP:  state_n = CHECK;
            CHECK:   state_n = bus.cache_read_hit ? IDLE : MEM_RD;
            MEM_RD:  if (bus.mem_ack) state_n = REFILL;
            REFILL:  state_n = IDLE;
            WRITE:   state_n = MEM_WR;
            MEM_WR:  if (bus.mem_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req         = 1'b0;
        bus.mem_we          = 1'b0;
        bus.cache_w_command = 1'b0;
        bus.cache_wdata     = wdata_q;
        unique case (state)
            MEM_RD: bus.mem_req = 1'b1;
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
            end
            WRITE:  bus.cache_w_command = 1'b1;
            REFILL: begin
                bus.cache_w_command = 1'b1;
                bus.cache_wdata     = data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ready_q && (bus.cpu_wr || bus.cpu_rd)) begin
                        addr_q <= bus.cpu_addr;
                        if (bus.cpu_wr) wdata_q <= bus.cpu_wdata;
                    end
                end
                CHECK: begin
                    if (bus.cache_read_hit) begin
                        rdata_q <= bus.cache_rdata;
                        ready_q <= 1'b1;
                    end
                end
                MEM_RD: if (bus.mem_ack) data_q <= bus.mem_rdata;
                REFILL: begin
                    rdata_q <= data_q;
                    ready_q <= 1'b1;
                end
                MEM_WR: if (bus.mem_ack) ready_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.cache_addr = addr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

`ifdef CACHE_CTRL_STATS_EN
    logic        hit_en, miss_en;
    logic [15:0] hit_cnt, miss_cnt;

    assign hit_en  = (state == CHECK) &&  bus.cache_read_hit;
    assign miss_en = (state == CHECK) && !bus.cache_read_hit;

    cache_stat_counter u_hit_cnt  (.clk(clk), .rst(rst), .en(hit_en),  .count(hit_cnt));
    cache_stat_counter u_miss_cnt (.clk(clk), .rst(rst), .en(miss_en), .count(miss_cnt));

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
`else
    assign bus.hit_count  = 16'h0000;
    assign bus.miss_count = 16'h0000;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache, a memory responder and a completion scoreboard.
module tb_cache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    cache_controller_if bus ();

    cache_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [15:0] d;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural cache: registered read result one cycle after the address is sampled.
    logic [15:0] cstore [logic [15:0]];
    always @(posedge clk) begin
        if (bus.cache_w_command === 1'b1) begin
            cstore[bus.cache_addr] = bus.cache_wdata;
            bus.cache_read_hit <= 1'b0;
        end else begin
            bus.cache_read_hit <= cstore.exists(bus.cache_addr);
            bus.cache_rdata    <= cstore.exists(bus.cache_addr) ? cstore[bus.cache_addr] : 16'h0000;
        end
    end

    // Memory responder: acks after mem_wait idle request cycles.
    int          mem_wait  = 0;
    logic [15:0] mem_data  = 16'h0000;
    bit          force_ack = 1'b0;
    int          mcnt      = 0;
    always @(negedge clk) begin
        if (force_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_data;
        end else if (bus.mem_req === 1'b1 && bus.mem_ack !== 1'b1) begin
            if (mcnt >= mem_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_data;
                mcnt          = 0;
            end else begin
                bus.mem_ack = 1'b0;
                mcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            if (bus.mem_req !== 1'b1) mcnt = 0;
        end
    end

    // Scoreboard: every completion must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.cpu_ready === 1'b1) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_ready: observed=completion expected=none");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.is_rd) chk("sb_rdata", {16'h0, bus.cpu_rdata}, {16'h0, e.d});
            end
        end
    end

    task automatic access(input string tag, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rdata,
                          input int exp_lat, input bit exp_mem);
        exp_t        e;
        int          cyc = 0, wcnt = 0, first_w = 0, reqc = 0;
        bit          done = 1'b0, bad = 1'b0;
        logic [15:0] wlast = 16'h0000;
        e.is_rd = !wr;
        e.d     = exp_rdata;
        sb.push_back(e);
        @(negedge clk);
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.cache_w_command === 1'b1) begin
                wcnt++;
                wlast = bus.cache_wdata;
                if (first_w == 0) first_w = cyc;
            end
            if (bus.mem_req === 1'b1) begin
                reqc++;
                if (bus.mem_we !== wr || bus.mem_addr !== addr || (wr && bus.mem_wdata !== wd)) bad = 1'b1;
            end
            if (bus.cpu_ready === 1'b1) done = 1'b1;
        end
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        chk({tag, "_done"},    32'(done),    32'd1);
        chk({tag, "_latency"}, 32'(cyc),     32'(exp_lat));
        chk({tag, "_req_cyc"}, 32'(reqc),    exp_mem ? 32'(mem_wait + 1) : 32'd0);
        chk({tag, "_mem_sig"}, 32'(bad),     32'd0);
        chk({tag, "_wcmd_n"},  32'(wcnt),    (wr || exp_mem) ? 32'd1 : 32'd0);
        if (wr || exp_mem) chk({tag, "_wdata"}, {16'h0, wlast}, {16'h0, (wr ? wd : exp_rdata)});
        if (wr) chk({tag, "_write_first"}, 32'(first_w), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  bad_rdy, bad_req;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;

        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.cpu_ready),       32'd0);
        chk("rst_rdata", {16'h0, bus.cpu_rdata},   32'd0);
        chk("rst_req",   32'(bus.mem_req),         32'd0);
        chk("rst_we",    32'(bus.mem_we),          32'd0);
        chk("rst_wcmd",  32'(bus.cache_w_command), 32'd0);
        chk("rst_addr",  {16'h0, bus.cache_addr},  32'd0);
        chk("rst_hits",  {16'h0, bus.hit_count},   32'd0);
        chk("rst_miss",  {16'h0, bus.miss_count},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mem_wait = 3; mem_data = 16'hBEEF;
        access("cold_miss", 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 8, 1'b1);
        access("hit_1234",  1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 3, 1'b0);
        mem_wait = 0;
        access("write",     1'b0, 1'b1, 16'h0A05, 16'h5555, 16'h0000, 3, 1'b1);
        access("hit_0a05",  1'b1, 1'b0, 16'h0A05, 16'h0000, 16'h5555, 3, 1'b0);
        access("both",      1'b1, 1'b1, 16'h0B00, 16'h7777, 16'h0000, 3, 1'b1);

`ifdef CACHE_CTRL_STATS_EN
        chk("stat_hits", {16'h0, bus.hit_count},  32'd2);
        chk("stat_miss", {16'h0, bus.miss_count}, 32'd1);
`else
        chk("stat_hits", {16'h0, bus.hit_count},  32'd0);
        chk("stat_miss", {16'h0, bus.miss_count}, 32'd0);
`endif

        mem_wait = 30;
        @(negedge clk);
        bus.cpu_rd = 1'b1; bus.cpu_addr = 16'h4000;
        cyc = 0;
        while (bus.mem_req !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_reached_memrd", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        bus.cpu_rd = 1'b0;
        #1;
        chk("mid_req",   32'(bus.mem_req),         32'd0);
        chk("mid_ready", 32'(bus.cpu_ready),       32'd0);
        chk("mid_we",    32'(bus.mem_we),          32'd0);
        chk("mid_rdata", {16'h0, bus.cpu_rdata},   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        bad_rdy = 1'b0; bad_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ready !== 1'b0) bad_rdy = 1'b1;
            if (bus.mem_req   !== 1'b0) bad_req = 1'b1;
        end
        chk("late_ack_ready", 32'(bad_rdy), 32'd0);
        chk("late_ack_req",   32'(bad_req), 32'd0);
        chk("post_rst_hits", {16'h0, bus.hit_count},  32'd0);
        chk("post_rst_miss", {16'h0, bus.miss_count}, 32'd0);

        access("hit_after_rst", 1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 3, 1'b0);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
